toplitz_row_gen: RTL

Streaming im2col (Toeplitz) generator for one conv layer. It reads the input feature map from the on-chip activation buffer and emits the Toeplitz matrix element by element: M = OUT_H*OUT_W rows of K = IN_C*KH*KW elements each. Padding positions are inserted as zeros. It sits between the activation SRAM and the systolic array's row-feed port. It is the producer side of the Toeplitz data that the array consumes and that the toy conv1 toplitz.csv captures.

---
 rtl/toplitz_pkg.sv | 28 ++
 rtl/toplitz_addr_gen.sv | 92 +++++++++
 rtl/toplitz_row_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/toplitz_pkg.sv
// Shared definitions for the Toeplitz (im2col) row generator.
//   fsm_t      : controller states, IDLE/RUN/DRAIN/FIN
//   elem_pos_t : element position {c, kh, kw, oh, ow} held by the address counters
//   out_dim()  : output height/width for a given input size, kernel size, pad and stride
package toplitz_pkg;

  localparam int POS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fsm_t;

  typedef struct packed {
    logic [POS_W-1:0] c;
    logic [POS_W-1:0] kh;
    logic [POS_W-1:0] kw;
    logic [POS_W-1:0] oh;
    logic [POS_W-1:0] ow;
  } elem_pos_t;

  function automatic int out_dim(input int in_dim, input int k, input int pad, input int stride);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/toplitz_addr_gen.sv
// Element-position counters for the Toeplitz generator.
// Walks rows m = oh*OUT_W+ow (outer) and, within a row, k = c*KH*KW+kh*KW+kw (kw fastest).
// For the current position it reports whether the element falls in the zero padding,
// the CHW activation address (c*IN_H+ih)*IN_W+iw, and whether it closes a row / the matrix.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : return to element 0 (new pass)
//   adv       : current element has been issued; step to the next one
//   is_pad    : current element is a padding position (no read needed)
//   addr      : activation address of the current element, 0 for pad elements
//   last_k    : current element is the last of its row
//   last      : current element is the last of the matrix
module toplitz_addr_gen
  import toplitz_pkg::*;
#(
  parameter int IN_H   = 5,
  parameter int IN_W   = 5,
  parameter int IN_C   = 1,
  parameter int KH     = 3,
  parameter int KW     = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 1,
  parameter int AW     = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clear,
  input  logic          adv,
  output logic          is_pad,
  output logic [AW-1:0] addr,
  output logic          last_k,
  output logic          last
);

  localparam int OUT_H = out_dim(IN_H, KH, PAD, STRIDE);
  localparam int OUT_W = out_dim(IN_W, KW, PAD, STRIDE);

  localparam logic [POS_W-1:0] ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] C_M1  = POS_W'(IN_C - 1);
  localparam logic [POS_W-1:0] KH_M1 = POS_W'(KH - 1);
  localparam logic [POS_W-1:0] KW_M1 = POS_W'(KW - 1);
  localparam logic [POS_W-1:0] OH_M1 = POS_W'(OUT_H - 1);
  localparam logic [POS_W-1:0] OW_M1 = POS_W'(OUT_W - 1);

  elem_pos_t pos, pos_nxt;
  int        ih, iw, lin;

  // Nested odometer: kw -> kh -> c -> ow -> oh, wrapping to zero after the last element.
  always_comb begin
    pos_nxt = pos;
    if (pos.kw != KW_M1) begin
      pos_nxt.kw = pos.kw + ONE;
    end else begin
      pos_nxt.kw = '0;
      if (pos.kh != KH_M1) begin
        pos_nxt.kh = pos.kh + ONE;
      end else begin
        pos_nxt.kh = '0;
        if (pos.c != C_M1) begin
          pos_nxt.c = pos.c + ONE;
        end else begin
          pos_nxt.c = '0;
          if (pos.ow != OW_M1) begin
            pos_nxt.ow = pos.ow + ONE;
          end else begin
            pos_nxt.ow = '0;
            if (pos.oh != OH_M1) pos_nxt.oh = pos.oh + ONE;
            else                 pos_nxt.oh = '0;
          end
        end
      end
    end
  end

  // Source coordinates are signed so positions left of / above the map go negative.
  always_comb begin
    ih     = int'(pos.oh) * STRIDE + int'(pos.kh) - PAD;
    iw     = int'(pos.ow) * STRIDE + int'(pos.kw) - PAD;
    is_pad = (ih < 0) || (ih >= IN_H) || (iw < 0) || (iw >= IN_W);
    lin    = (int'(pos.c) * IN_H + ih) * IN_W + iw;
    addr   = is_pad ? '0 : AW'(lin);
    last_k = (pos.c == C_M1) && (pos.kh == KH_M1) && (pos.kw == KW_M1);
    last   = last_k && (pos.oh == OH_M1) && (pos.ow == OW_M1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      pos <= '0;
    else if (clear) pos <= '0;
    else if (adv)   pos <= pos_nxt;
  end

endmodule

// File: rtl/toplitz_row_gen.sv
// Streaming im2col (Toeplitz) generator for one conv layer.
// Reads the CHW feature map from the activation buffer and emits OUT_H*OUT_W rows of
// IN_C*KH*KW elements, with zeros at padding positions.
// Ports:
//   CLK, nRST          : clock, asynchronous active-low reset
//   start              : one-cycle pulse, begins a pass (ignored unless idle)
//   busy / done        : pass in progress / one-cycle completion pulse
//   mem_ren, mem_addr  : activation read request; mem_rdata returns one cycle later
//   out_valid/out_ready: element handshake, out_data with out_last_k / out_last flags
//   dbg_state          : controller state
//   stall_cycles       : only when TOPLITZ_PERF_EN is defined; cycles with
//                        out_valid && !out_ready since start, saturating
// Handshake: an element transfers on a cycle where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_last_k/out_last hold and out_valid
// stays high.
module toplitz_row_gen
  import toplitz_pkg::*;
#(
  parameter int IN_H   = 5,
  parameter int IN_W   = 5,
  parameter int IN_C   = 1,
  parameter int KH     = 3,
  parameter int KW     = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 1,
  parameter int DW     = 8,
  parameter int AW     = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last_k,
  output logic          out_last,
  output fsm_t          dbg_state
`ifdef TOPLITZ_PERF_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  typedef struct packed {
    logic          last;
    logic          last_k;
    logic [DW-1:0] data;
  } fifo_word_t;

  fsm_t          state, state_nxt;
  logic          start_acc, issue, pop, push;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          inflight, slot_pad, slot_last_k, slot_last;
  logic          wr_ptr, rd_ptr;
  fifo_word_t    fifo_mem [2];
  fifo_word_t    head, wr_word;
  logic          ag_pad, ag_last_k, ag_last;
  logic [AW-1:0] ag_addr;

  toplitz_addr_gen #(
    .IN_H(IN_H), .IN_W(IN_W), .IN_C(IN_C), .KH(KH), .KW(KW),
    .STRIDE(STRIDE), .PAD(PAD), .AW(AW)
  ) u_addr_gen (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (start_acc),
    .adv    (issue),
    .is_pad (ag_pad),
    .addr   (ag_addr),
    .last_k (ag_last_k),
    .last   (ag_last)
  );

  assign start_acc = start && (state == IDLE);
  assign pop       = out_valid && out_ready;
  assign push      = inflight;

  // Slots already committed to the FIFO (stored + in flight), less the one leaving now.
  // Issuing only below 2 means a returning read always has a free FIFO entry.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == RUN) && (occ < 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (issue && ag_last) state_nxt = DRAIN;
      // Leave as the last entry is popped so done lands in the following cycle.
      DRAIN: if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pad slots travel through the same one-cycle slot as reads and become zero here.
  always_comb begin
    wr_word.last   = slot_last;
    wr_word.last_k = slot_last_k;
    wr_word.data   = slot_pad ? '0 : mem_rdata;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      inflight    <= 1'b0;
      slot_pad    <= 1'b0;
      slot_last_k <= 1'b0;
      slot_last   <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        slot_pad    <= ag_pad;
        slot_last_k <= ag_last_k;
        slot_last   <= ag_last;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= wr_word;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign out_valid  = (count != 2'd0);
  assign out_data   = head.data;
  assign out_last_k = out_valid && head.last_k;
  assign out_last   = out_valid && head.last;

  assign mem_ren   = issue && !ag_pad;
  assign mem_addr  = mem_ren ? ag_addr : '0;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);
  assign dbg_state = state;

`ifdef TOPLITZ_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                        stall_cycles <= '0;
    else if (start_acc)                               stall_cycles <= '0;
    else if (out_valid && !out_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
